// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default bit timing.
// Intended to be used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int UART_DEFAULT_CLK_PER_BIT = 5208;
    localparam int UART_DATA_BITS           = 8;

endpackage : uart_pkg

// File: rtl/uart_receiver_if.sv
// Receive-side byte interface between the UART receiver and the peripheral bus.
// The master drives the received byte and its status strobes; the slave consumes them.
interface uart_receiver_if;

    logic [uart_pkg::UART_DATA_BITS-1:0] rx_data;
    logic                                rx_status;
    logic                                rx_err;
    logic                                rx_busy;

    modport master (
        output rx_data,
        output rx_status,
        output rx_err,
        output rx_busy
    );

    modport slave (
        input rx_data,
        input rx_status,
        input rx_err,
        input rx_busy
    );

endinterface : uart_receiver_if

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous, idle-high input with a
// registered falling-edge pulse. The pulse is high in the same cycle that
// sync_o first shows the low level, so consumers see edge and level together.
module uart_rx_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic sync_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic fall_q;

    // Resynchronize the pin and flag a high-to-low transition of the synchronized level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            fall_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            fall_q <= sync_q & ~meta_q;
        end
    end

    assign sync_o = sync_q;
    assign fall_o = fall_q;

endmodule : uart_rx_sync

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: start-bit qualification at mid-bit, LSB-first data
// capture, stop-bit check. A good byte is presented with a one-cycle
// rx_status strobe; a low stop bit gives a one-cycle rx_err strobe instead.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = UART_DEFAULT_CLK_PER_BIT
) (
    input  logic            sysclk,
    input  logic            reset,
    input  logic            UART_rx,
    uart_receiver_if.master rx_bus
);

    localparam int CW = $clog2(CLK_PER_BIT);

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] HALF_M1  = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(CLK_PER_BIT - 1);

    logic rx_s;
    logic rx_fall_s;

    uart_state_e                  state_q;
    logic [CW-1:0]                cnt_q;
    logic [2:0]                   bit_idx_q;
    logic [UART_DATA_BITS-1:0]    shift_q;
    logic [UART_DATA_BITS-1:0]    rx_data_q;
    logic                         rx_status_q;
    logic                         rx_err_q;
    logic                         rx_busy_q;

    uart_rx_sync u_sync (
        .clk_i   (sysclk),
        .rst_ni  (reset),
        .async_i (UART_rx),
        .sync_o  (rx_s),
        .fall_o  (rx_fall_s)
    );

    // Frame FSM with bit-period counter, shift register and registered outputs.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= CNT_ZERO;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_status_q <= 1'b0;
            rx_err_q    <= 1'b0;
            rx_busy_q   <= 1'b0;
        end else begin
            // Strobes are single-cycle unless a sample point below raises them.
            rx_status_q <= 1'b0;
            rx_err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q     <= CNT_ZERO;
                    bit_idx_q <= 3'd0;
                    // Only a true high-to-low transition starts a frame, so a
                    // line left low after a framing error cannot retrigger.
                    if (rx_fall_s) begin
                        state_q   <= START;
                        rx_busy_q <= 1'b1;
                    end else begin
                        rx_busy_q <= 1'b0;
                    end
                end
                START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q <= CNT_ZERO;
                        if (!rx_s) begin
                            state_q   <= DATA;
                            bit_idx_q <= 3'd0;
                        end else begin
                            // Line is back high at mid start bit: treat as a glitch.
                            state_q   <= IDLE;
                            rx_busy_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= CNT_ZERO;
                        shift_q <= {rx_s, shift_q[UART_DATA_BITS-1:1]};
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                STOP: begin
                    if (cnt_q == FULL_M1) begin
                        // Leave at mid stop bit so a directly following start
                        // edge is seen from IDLE.
                        cnt_q     <= CNT_ZERO;
                        state_q   <= IDLE;
                        rx_busy_q <= 1'b0;
                        if (rx_s) begin
                            rx_data_q   <= shift_q;
                            rx_status_q <= 1'b1;
                        end else begin
                            rx_err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    cnt_q     <= CNT_ZERO;
                    bit_idx_q <= 3'd0;
                    rx_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign rx_bus.rx_data   = rx_data_q;
    assign rx_bus.rx_status = rx_status_q;
    assign rx_bus.rx_err    = rx_err_q;
    assign rx_bus.rx_busy   = rx_busy_q;

endmodule : uart_receiver

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at CLK_PER_BIT = 16 (clock period 10 units,
// nominal bit period 160 units).
module tb_uart_receiver;

    localparam int CPB    = 16;
    localparam int BIT_T  = CPB * 10;

    logic sysclk;
    logic reset;
    logic UART_rx;

    uart_receiver_if rx_if ();

    uart_receiver #(.CLK_PER_BIT(CPB)) dut (
        .sysclk  (sysclk),
        .reset   (reset),
        .UART_rx (UART_rx),
        .rx_bus  (rx_if)
    );

    int checks   = 0;
    int failures = 0;

    // Observation state filled by the monitor.
    int         cyc = 0;
    int         start_cyc = 0;
    int         stat_cyc = 0;
    int         err_cnt = 0;
    int         wide_cnt = 0;
    logic       prev_status = 1'b0;
    logic       prev_err = 1'b0;
    logic       prev_busy = 1'b0;
    logic       busy_before_pulse = 1'b0;
    logic       busy_at_pulse = 1'b0;
    logic [7:0] got_q[$];

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) cyc <= cyc + 1;

    // Monitor: sample outputs on the falling edge and log strobes.
    always @(negedge sysclk) begin
        if (rx_if.rx_status) begin
            got_q.push_back(rx_if.rx_data);
            stat_cyc          = cyc;
            busy_before_pulse = prev_busy;
            busy_at_pulse     = rx_if.rx_busy;
        end
        if (rx_if.rx_err) err_cnt = err_cnt + 1;
        if ((rx_if.rx_status && prev_status) || (rx_if.rx_err && prev_err))
            wide_cnt = wide_cnt + 1;
        prev_status = rx_if.rx_status;
        prev_err    = rx_if.rx_err;
        prev_busy   = rx_if.rx_busy;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_b, input int bit_t);
        @(negedge sysclk);
        start_cyc = cyc;
        UART_rx = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            UART_rx = b[i];
            #(bit_t);
        end
        UART_rx = stop_b;
        #(bit_t);
        UART_rx = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        UART_rx = 1'b1;
        idle(3);
        checks++; if (rx_if.rx_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", rx_if.rx_data); end
        checks++; if (rx_if.rx_status !== 1'b0) begin failures++; $display("FAIL reset_status got=%b exp=0", rx_if.rx_status); end
        checks++; if (rx_if.rx_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", rx_if.rx_err); end
        checks++; if (rx_if.rx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", rx_if.rx_busy); end
        reset = 1'b1;
        idle(5);
    endtask

    task automatic test_single();
        got_q.delete();
        err_cnt = 0;
        checks++; if (rx_if.rx_busy !== 1'b0) begin failures++; $display("FAIL a5_busy_idle got=%b exp=0", rx_if.rx_busy); end
        fork
            send_frame(8'hA5, 1'b1, BIT_T);
            begin
                idle(7);
                checks++; if (rx_if.rx_busy !== 1'b1) begin failures++; $display("FAIL a5_busy_mid got=%b exp=1", rx_if.rx_busy); end
            end
        join
        idle(20);
        checks++; if (got_q.size() !== 1) begin failures++; $display("FAIL a5_count got=%0d exp=1", got_q.size()); end
        checks++; if (rx_if.rx_data !== 8'hA5) begin failures++; $display("FAIL a5_data got=%h exp=a5", rx_if.rx_data); end
        checks++; if (err_cnt !== 0) begin failures++; $display("FAIL a5_err got=%0d exp=0", err_cnt); end
        // Pin low to strobe: 2 sync cycles + 1 to START + 8 + 9*16 - 1 + 1 register.
        checks++; if (stat_cyc - start_cyc !== 155) begin failures++; $display("FAIL a5_latency got=%0d exp=155", stat_cyc - start_cyc); end
        checks++; if (busy_before_pulse !== 1'b1) begin failures++; $display("FAIL a5_busy_before got=%b exp=1", busy_before_pulse); end
        checks++; if (busy_at_pulse !== 1'b0) begin failures++; $display("FAIL a5_busy_at_pulse got=%b exp=0", busy_at_pulse); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h3C;
        got_q.delete();
        err_cnt = 0;
        for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b1, BIT_T);
        idle(20);
        checks++; if (got_q.size() !== 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", got_q.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got_q.size() <= i) begin
                failures++; $display("FAIL b2b_byte%0d got=none exp=%h", i, exp_b[i]);
            end else if (got_q[i] !== exp_b[i]) begin
                failures++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, got_q[i], exp_b[i]);
            end
        end
        checks++; if (err_cnt !== 0) begin failures++; $display("FAIL b2b_err got=%0d exp=0", err_cnt); end
    endtask

    task automatic test_glitch();
        got_q.delete();
        err_cnt = 0;
        @(negedge sysclk);
        UART_rx = 1'b0;
        idle(4);
        UART_rx = 1'b1;
        idle(10);
        checks++; if (rx_if.rx_busy !== 1'b0) begin failures++; $display("FAIL glitch_busy got=%b exp=0", rx_if.rx_busy); end
        idle(200);
        checks++; if (got_q.size() !== 0) begin failures++; $display("FAIL glitch_status got=%0d exp=0", got_q.size()); end
        checks++; if (err_cnt !== 0) begin failures++; $display("FAIL glitch_err got=%0d exp=0", err_cnt); end
    endtask

    task automatic test_framing_error();
        got_q.delete();
        err_cnt = 0;
        send_frame(8'h81, 1'b0, BIT_T);
        UART_rx = 1'b0;
        #(40 * BIT_T);
        UART_rx = 1'b1;
        idle(10 * CPB);
        checks++; if (err_cnt !== 1) begin failures++; $display("FAIL ferr_count got=%0d exp=1", err_cnt); end
        checks++; if (got_q.size() !== 0) begin failures++; $display("FAIL ferr_status got=%0d exp=0", got_q.size()); end
        checks++; if (rx_if.rx_data !== 8'h3C) begin failures++; $display("FAIL ferr_data_kept got=%h exp=3c", rx_if.rx_data); end
        send_frame(8'h42, 1'b1, BIT_T);
        idle(20);
        checks++; if (rx_if.rx_data !== 8'h42) begin failures++; $display("FAIL ferr_recover got=%h exp=42", rx_if.rx_data); end
        checks++; if (got_q.size() !== 1) begin failures++; $display("FAIL ferr_recover_count got=%0d exp=1", got_q.size()); end
        checks++; if (err_cnt !== 1) begin failures++; $display("FAIL ferr_no_repeat got=%0d exp=1", err_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        b = 8'h55;
        got_q.delete();
        err_cnt = 0;
        @(negedge sysclk);
        UART_rx = 1'b0;
        #(BIT_T);
        for (int i = 0; i < 4; i++) begin
            UART_rx = b[i];
            #(BIT_T);
        end
        UART_rx = b[4];
        idle(8);
        reset   = 1'b0;
        UART_rx = 1'b1;
        idle(1);
        checks++; if (rx_if.rx_data !== 8'h00) begin failures++; $display("FAIL rst_mid_data got=%h exp=00", rx_if.rx_data); end
        checks++; if (rx_if.rx_busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", rx_if.rx_busy); end
        checks++; if (rx_if.rx_status !== 1'b0 || rx_if.rx_err !== 1'b0) begin failures++; $display("FAIL rst_mid_strobes got=%b%b exp=00", rx_if.rx_status, rx_if.rx_err); end
        idle(4);
        reset = 1'b1;
        idle(20 * CPB);
        checks++; if (got_q.size() !== 0 || err_cnt !== 0) begin failures++; $display("FAIL rst_mid_no_pulse got=%0d/%0d exp=0/0", got_q.size(), err_cnt); end
        send_frame(8'hC3, 1'b1, BIT_T);
        idle(20);
        checks++; if (rx_if.rx_data !== 8'hC3) begin failures++; $display("FAIL rst_mid_c3 got=%h exp=c3", rx_if.rx_data); end
    endtask

    task automatic test_skew();
        int periods [2];
        periods[0] = 155; periods[1] = 165;
        for (int k = 0; k < 2; k++) begin
            got_q.delete();
            err_cnt = 0;
            send_frame(8'h96, 1'b1, periods[k]);
            idle(20);
            checks++;
            if (got_q.size() !== 1 || rx_if.rx_data !== 8'h96) begin
                failures++; $display("FAIL skew_%0d_data got=%h n=%0d exp=96 n=1", periods[k], rx_if.rx_data, got_q.size());
            end
            checks++; if (err_cnt !== 0) begin failures++; $display("FAIL skew_%0d_err got=%0d exp=0", periods[k], err_cnt); end
        end
    endtask

    initial begin
        reset   = 1'b0;
        UART_rx = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_framing_error();
        test_reset_mid_frame();
        test_skew();
        checks++; if (wide_cnt !== 0) begin failures++; $display("FAIL strobe_width got=%0d exp=0", wide_cnt); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uart_receiver

// File: doc/uart_receiver.md
# uart_receiver

UART receiver for 8N1 serial frames: idle-high line, LSB-first, one start bit, eight data bits, one stop bit. It is the receive counterpart of the project's UART transmitter and sits between the board `UART_rx` pin and the processor's peripheral bus. It runs entirely on `sysclk` with an internal bit-period counter and samples each bit at mid-period. Each good byte is presented with a one-cycle valid pulse; bad frames are flagged instead.

## Interface
- `CLK_PER_BIT`, default 5208: `sysclk` cycles per bit (50 MHz / 9600 baud); legal range is 8..65535.
- `sysclk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low.
- `UART_rx`  in  1  asynchronous serial input; idles high.
- `rx_data`  out  8  last correctly received byte; holds until the next good frame.
- `rx_status`  out  1  one-cycle pulse: `rx_data` was just updated.
- `rx_err`  out  1  one-cycle pulse: framing error (stop bit sampled low).
- `rx_busy`  out  1  high while a frame is in progress (any state other than IDLE).

## Operation
- `UART_rx` passes through a 2-flop synchronizer; its reset value is 1.
- All FSM decisions use the synchronized line `rx_s`.
- A falling-edge detector compares `rx_s` with its previous value.
- States:
  - IDLE: counter and bit index held at 0. A falling edge on `rx_s` -> START, counter reset to 0.
  - START: count to `CLK_PER_BIT/2 - 1`, then sample.
    - `rx_s` = 0 -> DATA, counter 0, bit index 0.
    - `rx_s` = 1 -> glitch; return to IDLE with no outputs.
  - DATA: count to `CLK_PER_BIT - 1`, then sample.
    - Shift right with the new bit entering at bit 7, so the first-received bit ends in bit 0.
    - After 8 samples (bit index 7) -> STOP; otherwise increment the bit index.
  - STOP: count to `CLK_PER_BIT - 1`, then sample.
    - `rx_s` = 1 -> `rx_data` loads the shift register and `rx_status` pulses.
    - `rx_s` = 0 -> `rx_err` pulses and `rx_data` is unchanged.
    - Either way -> IDLE.
- Leaving at the middle of the stop bit allows back-to-back frames with no idle gap.
- After a framing error with the line still low, IDLE waits for the line to go high, then low again, before starting a new frame. A held-low line (break) therefore produces exactly one `rx_err` and no repeat.
- Unused state encodings go to IDLE.
- Counter width is `$clog2(CLK_PER_BIT)`. The counter never wraps: it is cleared at every sample point.

## Timing
- Reset values: `rx_data` = 8'h00, `rx_status` = 0, `rx_err` = 0, `rx_busy` = 0, FSM in IDLE, synchronizer flops = 1.
- Synchronizer plus edge-detect latency: 2 cycles from the pin to `rx_s`.
- Sample points, counted in `rx_s` cycles after the start-bit falling edge:
  - start bit: `CLK_PER_BIT/2`
  - data bit n: `CLK_PER_BIT/2 + (n+1)*CLK_PER_BIT`, for n = 0..7
  - stop bit: `CLK_PER_BIT/2 + 9*CLK_PER_BIT`
- `rx_status`/`rx_err` are registered and assert in the cycle after the stop sample, for exactly one cycle.
- `rx_data` changes in the same cycle that `rx_status` rises.
- `rx_busy` rises in the cycle after the falling edge is detected. It falls in the same cycle that `rx_status`/`rx_err` assert.
- Reset asserted mid-frame: everything returns immediately to the reset values; the partial byte is discarded with no pulse.
- Edges on `rx_s` outside IDLE are ignored.
- There is no backpressure: a consumer must take `rx_data` before the next `rx_status` (at least 9.5 bit times later).

## Structure
- Package `uart_pkg`:
  - FSM state enum {IDLE, START, DATA, STOP};
  - `UART_DEFAULT_CLK_PER_BIT` = 5208;
  - `UART_DATA_BITS` = 8.
  - The transmitter should share this package.
- Sub-module `uart_rx_sync`: 2-flop synchronizer with reset-to-1 and registered falling-edge pulse output. Reusable for other asynchronous inputs.
- Top level holds the FSM, bit-period counter, 3-bit bit index, shift register and output registers.

## Test plan
All scenarios use `CLK_PER_BIT` = 16.
- Send frame 8'hA5 -> exactly one `rx_status` pulse, 1 cycle wide, with `rx_data` = 8'hA5, `rx_err` = 0. `rx_busy` high from just after the start edge until the pulse.
- Send 8'h00, 8'hFF, 8'h3C back-to-back (stop bit directly followed by next start) -> three `rx_status` pulses carrying the correct bytes, in order.
- 4-cycle low glitch on an idle line -> no `rx_status`, no `rx_err`; `rx_busy` returns to 0 within 10 cycles.
- Frame 8'h81 with the stop bit driven low, then the line held low for 40 bit times -> one `rx_err`, `rx_data` keeps its previous value. A following good 8'h42 after the line returns high -> `rx_data` = 8'h42.
- Assert `reset` during data bit 4 of 8'h55 -> all outputs at reset values; a subsequent 8'hC3 is received correctly.
- Bit timing skewed ±3% (bit period 15.5/16.5 cycles) on 8'h96 -> `rx_data` = 8'h96, no `rx_err`.
